// File: rtl/oam_dma_if.sv
// Bus bundle between the CPU memory port, the OAM DMA engine and the system bus.
// The slave modport is the DMA engine's view; the master modport is the
// surrounding CPU and memory system.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic        cpu_enable;
  logic        cpu_write;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in;
  logic [15:0] ext_addr;
  logic        ext_enable;
  logic        ext_write;
  logic [7:0]  ext_data_out;
  logic [7:0]  ext_data_in;

  modport master (
    output cpu_addr, cpu_enable, cpu_write, cpu_data_out, ext_data_in,
    input  cpu_data_in, ext_addr, ext_enable, ext_write, ext_data_out
  );

  modport slave (
    input  cpu_addr, cpu_enable, cpu_write, cpu_data_out, ext_data_in,
    output cpu_data_in, ext_addr, ext_enable, ext_write, ext_data_out
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine and system-bus arbiter. Sits between the CPU memory port and
// the system bus, owns the DMA source register and copies DMA_LENGTH bytes
// from {source, 0x00} into OAM, one byte per M-cycle. While copying, the CPU
// only keeps access to its own register; everything else reads 0xFF and
// writes are dropped.
module oam_dma #(
  parameter int          DMA_LENGTH  = 160,
  parameter int          START_DELAY = 1,
  parameter logic [15:0] REG_ADDR    = 16'hFF46
) (
  input  logic       clk,
  input  logic       reset,
  oam_dma_if.slave   bus,
  output logic [7:0] oam_addr,
  output logic       oam_write,
  output logic [7:0] oam_data,
  output logic       dma_active
);

  localparam logic [7:0] LAST_INDEX = 8'(DMA_LENGTH - 1);
  localparam logic [7:0] DELAY_INIT = 8'(START_DELAY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    COPY  = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] phase;
  logic [7:0] delay;
  logic [7:0] index;
  logic [7:0] page;
  logic [7:0] src;

  logic reg_access;
  logic trigger;
  logic continue_old;

  // Echo RAM pages 0xE0-0xFF alias onto work RAM 0xC0-0xDF.
  function automatic logic [7:0] effective_page(input logic [7:0] value);
    return (value >= 8'hE0) ? (value - 8'h20) : value;
  endfunction

  assign reg_access   = (bus.cpu_addr == REG_ADDR);
  assign trigger      = bus.cpu_enable && bus.cpu_write && reg_access;
  assign continue_old = dma_active && (index != LAST_INDEX);

  // Phase counter, source register and copy sequencer; everything except the
  // phase commits on the M-cycle boundary (phase 3).
  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= 2'd0;
      state      <= IDLE;
      delay      <= 8'd0;
      index      <= 8'd0;
      page       <= 8'd0;
      src        <= 8'd0;
      oam_write  <= 1'b0;
      oam_addr   <= 8'd0;
      oam_data   <= 8'd0;
      dma_active <= 1'b0;
    end else begin
      phase     <= phase + 2'd1;
      oam_write <= 1'b0;
      if (phase == 2'd3) begin
        if (dma_active) begin
          oam_write <= 1'b1;
          oam_addr  <= index;
          oam_data  <= bus.ext_data_in;
        end
        if (trigger) begin
          src <= bus.cpu_data_out;
          if (START_DELAY == 0) begin
            state      <= COPY;
            dma_active <= 1'b1;
            index      <= 8'd0;
            page       <= effective_page(bus.cpu_data_out);
          end else begin
            state      <= START;
            delay      <= DELAY_INIT;
            dma_active <= continue_old;
            if (dma_active) begin
              index <= index + 8'd1;
            end
          end
        end else begin
          case (state)
            IDLE: begin
              dma_active <= 1'b0;
            end
            START: begin
              if (delay == 8'd1) begin
                state      <= COPY;
                dma_active <= 1'b1;
                index      <= 8'd0;
                page       <= effective_page(src);
              end else begin
                delay      <= delay - 8'd1;
                dma_active <= continue_old;
                if (dma_active) begin
                  index <= index + 8'd1;
                end
              end
            end
            COPY: begin
              if (index == LAST_INDEX) begin
                state      <= IDLE;
                dma_active <= 1'b0;
              end else begin
                index <= index + 8'd1;
              end
            end
            default: begin
              state      <= IDLE;
              dma_active <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Bus arbitration: the copy owns the system bus; otherwise the CPU passes
  // through, except for the source register which is answered locally.
  always_comb begin
    bus.ext_addr     = 16'h0000;
    bus.ext_enable   = 1'b0;
    bus.ext_write    = 1'b0;
    bus.ext_data_out = 8'h00;
    bus.cpu_data_in  = 8'hFF;
    if (reset) begin
      bus.cpu_data_in = 8'hFF;
    end else if (dma_active) begin
      bus.ext_addr   = {page, index};
      bus.ext_enable = 1'b1;
      if (reg_access) begin
        bus.cpu_data_in = src;
      end
    end else if (reg_access) begin
      bus.cpu_data_in = src;
    end else begin
      bus.ext_addr     = bus.cpu_addr;
      bus.ext_enable   = bus.cpu_enable;
      bus.ext_write    = bus.cpu_write;
      bus.ext_data_out = bus.cpu_data_out;
      bus.cpu_data_in  = bus.ext_data_in;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed testbench for oam_dma: full copies, echo-page mapping, CPU
// blocking during a copy, retriggers mid-copy and on the final byte, and
// reset in the middle of a transfer.
module tb_oam_dma;

  logic       clk;
  logic       reset;
  logic [7:0] oam_addr;
  logic       oam_write;
  logic [7:0] oam_data;
  logic       dma_active;

  int passed;
  int total;
  int wr_count;
  int active_clocks;
  int wr_snap;
  int active_snap;

  oam_dma_if bus ();

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .oam_addr   (oam_addr),
    .oam_write  (oam_write),
    .oam_data   (oam_data),
    .dma_active (dma_active)
  );

  // Memory image: byte k of page 0xC1 holds k^0x5A; other pages are offset so
  // a wrong page shows up in the copied data too.
  function automatic logic [7:0] mem_byte(input logic [15:0] addr);
    return addr[7:0] ^ 8'h5A ^ (addr[15:8] - 8'hC1);
  endfunction

  assign bus.ext_data_in = mem_byte(bus.ext_addr);

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count OAM write pulses and active clocks, sampled mid-period.
  always @(negedge clk) begin
    if (oam_write) wr_count++;
    if (dma_active) active_clocks++;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] addr, input logic enable,
                                input logic write, input logic [7:0] data);
    bus.cpu_addr     = addr;
    bus.cpu_enable   = enable;
    bus.cpu_write    = write;
    bus.cpu_data_out = data;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic m_cycle();
    repeat (4) tick();
  endtask

  // One copy M-cycle: bus ownership during the cycle, pulse width, and the
  // OAM write that lands on the boundary.
  task automatic copy_mcycle(input logic [15:0] addr, input logic [7:0] idx);
    check_output("copy_active", 32'(dma_active), 32'd1);
    check_output("copy_ext_addr", 32'(bus.ext_addr), 32'(addr));
    check_output("copy_ext_enable", 32'(bus.ext_enable), 32'd1);
    check_output("copy_ext_write", 32'(bus.ext_write), 32'd0);
    tick();
    check_output("oam_pulse_width", 32'(oam_write), 32'd0);
    repeat (3) tick();
    check_output("oam_write", 32'(oam_write), 32'd1);
    check_output("oam_addr", 32'(oam_addr), 32'(idx));
    check_output("oam_data", 32'(oam_data), 32'(mem_byte(addr)));
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    apply_stimulus(16'h1234, 1'b1, 1'b1, 8'h77);

    // Reset state, with a live CPU access that must not leak out.
    repeat (3) tick();
    check_output("rst_ext_enable", 32'(bus.ext_enable), 32'd0);
    check_output("rst_ext_write", 32'(bus.ext_write), 32'd0);
    check_output("rst_ext_addr", 32'(bus.ext_addr), 32'd0);
    check_output("rst_ext_data_out", 32'(bus.ext_data_out), 32'd0);
    check_output("rst_cpu_data_in", 32'(bus.cpu_data_in), 32'hFF);
    check_output("rst_oam_write", 32'(oam_write), 32'd0);
    check_output("rst_oam_addr", 32'(oam_addr), 32'd0);
    check_output("rst_oam_data", 32'(oam_data), 32'd0);
    check_output("rst_dma_active", 32'(dma_active), 32'd0);
    reset = 1'b0;

    // Pass-through write, read, and local register read.
    apply_stimulus(16'h1234, 1'b1, 1'b1, 8'h77);
    check_output("pass_wr_addr", 32'(bus.ext_addr), 32'h1234);
    check_output("pass_wr_enable", 32'(bus.ext_enable), 32'd1);
    check_output("pass_wr_write", 32'(bus.ext_write), 32'd1);
    check_output("pass_wr_data", 32'(bus.ext_data_out), 32'h77);
    m_cycle();
    apply_stimulus(16'h1234, 1'b1, 1'b0, 8'h00);
    check_output("pass_rd_write", 32'(bus.ext_write), 32'd0);
    check_output("pass_rd_data", 32'(bus.cpu_data_in), 32'(mem_byte(16'h1234)));
    m_cycle();
    apply_stimulus(16'hFF46, 1'b1, 1'b0, 8'h00);
    check_output("reg_rd_reset_val", 32'(bus.cpu_data_in), 32'h00);
    check_output("reg_rd_not_fwd", 32'(bus.ext_enable), 32'd0);
    m_cycle();

    // Full copy from page 0xC1.
    wr_snap     = wr_count;
    active_snap = active_clocks;
    apply_stimulus(16'hFF46, 1'b1, 1'b1, 8'hC1);
    check_output("reg_wr_not_fwd", 32'(bus.ext_enable), 32'd0);
    m_cycle();
    apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00);
    check_output("start_idle_active", 32'(dma_active), 32'd0);
    m_cycle();
    check_output("start_idle_no_write", 32'(oam_write), 32'd0);
    for (int k = 0; k < 160; k++) copy_mcycle(16'hC100 + 16'(k), 8'(k));
    check_output("c1_done_active", 32'(dma_active), 32'd0);
    check_output("c1_done_bus_idle", 32'(bus.ext_enable), 32'd0);
    tick();
    check_output("c1_pulse_count", 32'(wr_count - wr_snap), 32'd160);
    check_output("c1_active_clocks", 32'(active_clocks - active_snap), 32'd640);
    repeat (3) tick();

    // Echo page 0xE3 maps to 0xC3; CPU is blocked during the copy.
    apply_stimulus(16'hFF46, 1'b1, 1'b1, 8'hE3);
    m_cycle();
    apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00);
    m_cycle();
    for (int k = 0; k < 160; k++) begin
      if (k == 5) begin
        apply_stimulus(16'hC000, 1'b1, 1'b0, 8'h00);
        check_output("blk_rd_data", 32'(bus.cpu_data_in), 32'hFF);
      end else if (k == 6) begin
        apply_stimulus(16'hC000, 1'b1, 1'b1, 8'h33);
        check_output("blk_wr_dropped", 32'(bus.ext_write), 32'd0);
      end else if (k == 7) begin
        apply_stimulus(16'hFF80, 1'b1, 1'b0, 8'h00);
        check_output("blk_hram_rd", 32'(bus.cpu_data_in), 32'hFF);
      end else if (k == 8) begin
        apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00);
      end
      copy_mcycle(16'hC300 + 16'(k), 8'(k));
    end
    m_cycle();

    // Register readback during the start delay, then reset at index 10.
    apply_stimulus(16'hFF46, 1'b1, 1'b1, 8'h80);
    m_cycle();
    apply_stimulus(16'hFF46, 1'b1, 1'b0, 8'h00);
    check_output("reg_rd_80", 32'(bus.cpu_data_in), 32'h80);
    check_output("reg_rd_80_not_fwd", 32'(bus.ext_enable), 32'd0);
    check_output("reg_rd_80_delay", 32'(dma_active), 32'd0);
    m_cycle();
    apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) copy_mcycle(16'h8000 + 16'(k), 8'(k));
    check_output("pre_rst_active", 32'(dma_active), 32'd1);
    check_output("pre_rst_addr", 32'(bus.ext_addr), 32'h800A);
    tick();
    reset = 1'b1;
    apply_stimulus(16'h1234, 1'b1, 1'b0, 8'h00);
    tick();
    check_output("abort_oam_write", 32'(oam_write), 32'd0);
    check_output("abort_active", 32'(dma_active), 32'd0);
    check_output("abort_ext_enable", 32'(bus.ext_enable), 32'd0);
    wr_snap = wr_count;
    tick();
    reset = 1'b0;
    apply_stimulus(16'hFF46, 1'b1, 1'b0, 8'h00);
    check_output("abort_reg_val", 32'(bus.cpu_data_in), 32'h00);
    m_cycle();
    apply_stimulus(16'h1234, 1'b1, 1'b0, 8'h00);
    check_output("abort_pass_addr", 32'(bus.ext_addr), 32'h1234);
    check_output("abort_pass_enable", 32'(bus.ext_enable), 32'd1);
    check_output("abort_pass_data", 32'(bus.cpu_data_in), 32'(mem_byte(16'h1234)));
    m_cycle();
    m_cycle();
    check_output("abort_no_writes", 32'(wr_count - wr_snap), 32'd0);
    check_output("abort_still_idle", 32'(dma_active), 32'd0);

    // Retrigger at index 49 with 0xD0, then again on the final byte with 0x90.
    wr_snap = wr_count;
    apply_stimulus(16'hFF46, 1'b1, 1'b1, 8'hC1);
    m_cycle();
    apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00);
    m_cycle();
    for (int k = 0; k < 49; k++) copy_mcycle(16'hC100 + 16'(k), 8'(k));
    apply_stimulus(16'hFF46, 1'b1, 1'b1, 8'hD0);
    copy_mcycle(16'hC131, 8'd49);
    apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00);
    copy_mcycle(16'hC132, 8'd50);
    for (int k = 0; k < 159; k++) copy_mcycle(16'hD000 + 16'(k), 8'(k));
    apply_stimulus(16'hFF46, 1'b1, 1'b1, 8'h90);
    copy_mcycle(16'hD09F, 8'd159);
    apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00);
    check_output("final_retrig_delay", 32'(dma_active), 32'd0);
    m_cycle();
    copy_mcycle(16'h9000, 8'd0);
    tick();
    check_output("retrig_pulse_count", 32'(wr_count - wr_snap), 32'd212);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
